// File: rtl/reset_timer_core.sv
// Power-up / post-reset pulse generator: holds reset_out high for LOAD clk edges
// after rst releases, exposing the down-counter for debug.
module reset_timer_core #(
    parameter int unsigned CLOCK_HZ = 48000000,
    parameter int unsigned TIME_NS  = 255
) (
    input  logic       clk,
    input  logic       rst,
    output logic       reset_out,
    output logic [7:0] counter_out,
    output logic       counter_non_zero
);

    // Round up so the pulse is never shorter than TIME_NS.
    localparam logic [63:0] LOAD_RAW =
        (64'(CLOCK_HZ) * 64'(TIME_NS) + 64'd999_999_999) / 64'd1_000_000_000;
    localparam logic [7:0]  LOAD     =
        (LOAD_RAW > 64'd255) ? 8'd255 : LOAD_RAW[7:0];

    // Init value gives the pulse at configuration time without any rst edge.
    logic [7:0] r_counter = LOAD;
    logic       w_non_zero;

    assign w_non_zero = (r_counter != 8'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_counter <= LOAD;
        end else if (w_non_zero) begin
            r_counter <= r_counter - 8'd1;
        end
    end

    assign counter_out      = r_counter;
    assign counter_non_zero = w_non_zero;
    assign reset_out        = rst | w_non_zero;

endmodule

// File: tb/tb_reset_timer_core.sv
// Directed bench: default (LOAD=13), clamped (LOAD=255) and zero-length (LOAD=0) instances.
module tb_reset_timer_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       d_ro,  c_ro,  z_ro;
    logic [7:0] d_cnt, c_cnt, z_cnt;
    logic       d_nz,  c_nz,  z_nz;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    reset_timer_core dut_def (
        .clk(clk), .rst(rst), .reset_out(d_ro),
        .counter_out(d_cnt), .counter_non_zero(d_nz)
    );

    reset_timer_core #(.CLOCK_HZ(48000000), .TIME_NS(10000)) dut_clamp (
        .clk(clk), .rst(rst), .reset_out(c_ro),
        .counter_out(c_cnt), .counter_non_zero(c_nz)
    );

    reset_timer_core #(.CLOCK_HZ(48000000), .TIME_NS(0)) dut_zero (
        .clk(clk), .rst(rst), .reset_out(z_ro),
        .counter_out(z_cnt), .counter_non_zero(z_nz)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (d_cnt !== 8'd13 || d_ro !== 1'b1 || d_nz !== 1'b1) begin
            errors++;
            $display("FAIL powerup_def: cnt=%0d ro=%b nz=%b, want 13 1 1", d_cnt, d_ro, d_nz);
        end
        checks++;
        if (c_cnt !== 8'd255 || c_ro !== 1'b1) begin
            errors++;
            $display("FAIL powerup_clamp: cnt=%0d ro=%b, want 255 1", c_cnt, c_ro);
        end
        checks++;
        if (z_cnt !== 8'd0 || z_ro !== 1'b0 || z_nz !== 1'b0) begin
            errors++;
            $display("FAIL powerup_zero: cnt=%0d ro=%b nz=%b, want 0 0 0", z_cnt, z_ro, z_nz);
        end
    endtask

    task automatic test_powerup_count();
        for (int k = 1; k <= 13; k++) begin
            tick();
            checks++;
            if (d_cnt !== 8'(13 - k) || d_ro !== (k < 13) || d_nz !== (k < 13)) begin
                errors++;
                $display("FAIL powerup_count[%0d]: cnt=%0d ro=%b nz=%b, want %0d %b", k,
                         d_cnt, d_ro, d_nz, 13 - k, k < 13);
            end
        end
    endtask

    task automatic test_rst_mid();
        tick();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        repeat (8) tick();
        checks++;
        if (d_cnt !== 8'd5) begin
            errors++;
            $display("FAIL mid_pre: cnt=%0d, want 5", d_cnt);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (d_cnt !== 8'd13 || d_ro !== 1'b1 || z_ro !== 1'b1 || z_cnt !== 8'd0) begin
            errors++;
            $display("FAIL mid_async: cnt=%0d ro=%b zro=%b zcnt=%0d, want 13 1 1 0",
                     d_cnt, d_ro, z_ro, z_cnt);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (z_ro !== 1'b0 || d_cnt !== 8'd13 || d_ro !== 1'b1) begin
            errors++;
            $display("FAIL mid_release: zro=%b cnt=%0d ro=%b, want 0 13 1", z_ro, d_cnt, d_ro);
        end
        for (int k = 1; k <= 13; k++) begin
            tick();
            checks++;
            if (d_cnt !== 8'(13 - k) || d_ro !== (k < 13)) begin
                errors++;
                $display("FAIL mid_count[%0d]: cnt=%0d ro=%b, want %0d %b", k,
                         d_cnt, d_ro, 13 - k, k < 13);
            end
        end
    endtask

    task automatic test_hold();
        rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (d_cnt !== 8'd13 || d_ro !== 1'b1 || z_ro !== 1'b1 || c_cnt !== 8'd255) begin
                errors++;
                $display("FAIL hold[%0d]: cnt=%0d ro=%b zro=%b ccnt=%0d, want 13 1 1 255", k,
                         d_cnt, d_ro, z_ro, c_cnt);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            tick();
            checks++;
            if (d_cnt !== 8'(13 - k) || d_nz !== (k < 13) || d_ro !== (k < 13)
                || z_ro !== 1'b0) begin
                errors++;
                $display("FAIL hold_count[%0d]: cnt=%0d nz=%b ro=%b zro=%b, want %0d %b", k,
                         d_cnt, d_nz, d_ro, z_ro, 13 - k, k < 13);
            end
        end
    endtask

    task automatic test_terminal();
        int bad = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (d_cnt !== 8'd0 || d_ro !== 1'b0 || d_nz !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || d_cnt !== 8'd0) begin
            errors++;
            $display("FAIL terminal: %0d bad cycles, last cnt=%0d ro=%b, want 0 0", bad,
                     d_cnt, d_ro);
        end
        checks++;
        if (c_cnt !== 8'd0 || c_ro !== 1'b0) begin
            errors++;
            $display("FAIL clamp_after_hold: cnt=%0d ro=%b, want 0 0", c_cnt, c_ro);
        end
    endtask

    task automatic test_clamp();
        int bad = 0;
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (c_cnt !== 8'd255 || c_ro !== 1'b1) begin
            errors++;
            $display("FAIL clamp_load: cnt=%0d ro=%b, want 255 1", c_cnt, c_ro);
        end
        rst = 1'b0;
        for (int k = 1; k <= 255; k++) begin
            tick();
            if (c_cnt !== 8'(255 - k) || c_ro !== (k < 255)) bad++;
            if (k == 254) begin
                checks++;
                if (c_cnt !== 8'd1 || c_ro !== 1'b1) begin
                    errors++;
                    $display("FAIL clamp_edge254: cnt=%0d ro=%b, want 1 1", c_cnt, c_ro);
                end
            end
        end
        checks++;
        if (bad != 0 || c_cnt !== 8'd0 || c_ro !== 1'b0) begin
            errors++;
            $display("FAIL clamp_count: %0d bad cycles, last cnt=%0d ro=%b, want 0 0", bad,
                     c_cnt, c_ro);
        end
        checks++;
        if (z_cnt !== 8'd0 || z_ro !== rst || z_nz !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle: cnt=%0d ro=%b nz=%b, want 0 %b 0", z_cnt, z_ro, z_nz, rst);
        end
    endtask

    initial begin
        test_reset();
        test_powerup_count();
        test_rst_mid();
        test_hold();
        test_terminal();
        test_clamp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
